// File: rtl/int_alu_pkg.sv
// Shared constants and helpers for the int_alu datapath.
// Holds operand-mode encodings and partial-product chunk sizing.
package int_alu_pkg;

    localparam int unsigned DATA_WIDTH_DEFAULT = 32;

    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

    // Multiplier bits consumed by each pipeline stage.
    function automatic int unsigned chunk_width(input int unsigned data_width,
                                                input int unsigned stages);
        return data_width / stages;
    endfunction

endpackage

// File: rtl/int_mult_pipe_stage.sv
// One multiplier pipeline slice: adds its chunk of partial products,
// optionally negates on the final stage, and computes its own advance.
module int_mult_pipe_stage
    import int_alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int unsigned STAGES     = 4,
    parameter int unsigned TAG_WIDTH  = 4,
    parameter int unsigned STAGE_IDX  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    prev_valid_i,
    input  logic [TAG_WIDTH-1:0]    prev_tag_i,
    input  logic                    prev_neg_i,
    input  logic [DATA_WIDTH-1:0]   prev_a_i,
    input  logic [DATA_WIDTH-1:0]   prev_b_i,
    input  logic [2*DATA_WIDTH-1:0] prev_acc_i,
    input  logic                    next_adv_i,
    output logic                    adv_c,
    output logic                    valid_o,
    output logic [TAG_WIDTH-1:0]    tag_o,
    output logic                    neg_o,
    output logic [DATA_WIDTH-1:0]   a_o,
    output logic [DATA_WIDTH-1:0]   b_o,
    output logic [2*DATA_WIDTH-1:0] acc_o
);

    localparam int unsigned PW      = 2 * DATA_WIDTH;
    localparam int unsigned K       = chunk_width(DATA_WIDTH, STAGES);
    localparam int unsigned LO      = STAGE_IDX * K;
    localparam bit          IS_LAST = (STAGE_IDX == STAGES - 1);

    logic                  valid_q, valid_d;
    logic [TAG_WIDTH-1:0]  tag_q;
    logic                  neg_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [PW-1:0]         acc_q, acc_d;
    logic [PW-1:0]         sum_c;
    logic                  load_c;

    // An empty slot always accepts, so bubbles collapse toward the output.
    assign adv_c  = ~valid_q | next_adv_i;
    assign load_c = adv_c & prev_valid_i;

    always_comb begin
        sum_c = prev_acc_i;
        for (int unsigned j = 0; j < K; j++) begin
            if (prev_b_i[LO + j]) begin
                sum_c = sum_c + (PW'(prev_a_i) << (LO + j));
            end
        end
        acc_d   = (IS_LAST && prev_neg_i) ? (-sum_c) : sum_c;
        valid_d = adv_c ? prev_valid_i : valid_q;
    end

    // Payload only moves with a valid operation; invalid slots keep stale data.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            neg_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
        end else begin
            valid_q <= valid_d;
            if (load_c) begin
                tag_q <= prev_tag_i;
                neg_q <= prev_neg_i;
                a_q   <= prev_a_i;
                b_q   <= prev_b_i;
                acc_q <= acc_d;
            end
        end
    end

    assign valid_o = valid_q;
    assign tag_o   = tag_q;
    assign neg_o   = neg_q;
    assign a_o     = a_q;
    assign b_o     = b_q;
    assign acc_o   = acc_q;

endmodule

// File: rtl/int_mult_pipe.sv
// Fully pipelined DATA_WIDTH x DATA_WIDTH integer multiplier with
// signed/unsigned mode, sideband tag and valid/ready backpressure.
module int_mult_pipe
    import int_alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int unsigned STAGES     = 4,
    parameter int unsigned TAG_WIDTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_signed,
    input  logic [TAG_WIDTH-1:0]    in_tag,
    input  logic [DATA_WIDTH-1:0]   data_a,
    input  logic [DATA_WIDTH-1:0]   data_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [TAG_WIDTH-1:0]    out_tag,
    output logic [2*DATA_WIDTH-1:0] product
);

    localparam int unsigned PW = 2 * DATA_WIDTH;

    logic                  adv_w   [STAGES];
    logic                  valid_w [STAGES];
    logic [TAG_WIDTH-1:0]  tag_w   [STAGES];
    logic                  neg_w   [STAGES];
    logic [DATA_WIDTH-1:0] a_w     [STAGES];
    logic [DATA_WIDTH-1:0] b_w     [STAGES];
    logic [PW-1:0]         acc_w   [STAGES];

    logic                  a_neg_c;
    logic                  b_neg_c;
    logic [DATA_WIDTH-1:0] a_mag_c;
    logic [DATA_WIDTH-1:0] b_mag_c;
    logic                  neg_c;

    // Magnitude of the most negative value is 2^(W-1), which still fits unsigned.
    always_comb begin
        a_neg_c = (in_signed == MODE_SIGNED) && data_a[DATA_WIDTH-1];
        b_neg_c = (in_signed == MODE_SIGNED) && data_b[DATA_WIDTH-1];
        a_mag_c = a_neg_c ? (-data_a) : data_a;
        b_mag_c = b_neg_c ? (-data_b) : data_b;
        neg_c   = a_neg_c ^ b_neg_c;
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic                  prev_valid;
        logic [TAG_WIDTH-1:0]  prev_tag;
        logic                  prev_neg;
        logic [DATA_WIDTH-1:0] prev_a;
        logic [DATA_WIDTH-1:0] prev_b;
        logic [PW-1:0]         prev_acc;
        logic                  next_adv;

        if (s == 0) begin : g_first
            assign prev_valid = in_valid;
            assign prev_tag   = in_tag;
            assign prev_neg   = neg_c;
            assign prev_a     = a_mag_c;
            assign prev_b     = b_mag_c;
            assign prev_acc   = '0;
        end else begin : g_chain
            assign prev_valid = valid_w[s-1];
            assign prev_tag   = tag_w[s-1];
            assign prev_neg   = neg_w[s-1];
            assign prev_a     = a_w[s-1];
            assign prev_b     = b_w[s-1];
            assign prev_acc   = acc_w[s-1];
        end

        if (s == STAGES - 1) begin : g_tail
            assign next_adv = out_ready;
        end else begin : g_body
            assign next_adv = adv_w[s+1];
        end

        int_mult_pipe_stage #(
            .DATA_WIDTH (DATA_WIDTH),
            .STAGES     (STAGES),
            .TAG_WIDTH  (TAG_WIDTH),
            .STAGE_IDX  (s)
        ) u_stage (
            .clk          (clk),
            .rst          (rst),
            .prev_valid_i (prev_valid),
            .prev_tag_i   (prev_tag),
            .prev_neg_i   (prev_neg),
            .prev_a_i     (prev_a),
            .prev_b_i     (prev_b),
            .prev_acc_i   (prev_acc),
            .next_adv_i   (next_adv),
            .adv_c        (adv_w[s]),
            .valid_o      (valid_w[s]),
            .tag_o        (tag_w[s]),
            .neg_o        (neg_w[s]),
            .a_o          (a_w[s]),
            .b_o          (b_w[s]),
            .acc_o        (acc_w[s])
        );
    end

    assign in_ready  = adv_w[0];
    assign out_valid = valid_w[STAGES-1];
    assign out_tag   = tag_w[STAGES-1];
    assign product   = acc_w[STAGES-1];

endmodule

// File: tb/tb_int_mult_pipe.sv
// Self-checking bench for int_mult_pipe: directed corners plus randomized
// traffic scored against a plain-arithmetic reference and an in-order queue.
module tb_int_mult_pipe;

    localparam int unsigned W  = 32;
    localparam int unsigned S  = 4;
    localparam int unsigned TW = 4;
    localparam int unsigned PW = 2 * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, in_signed;
    logic [TW-1:0] in_tag, out_tag;
    logic [W-1:0]  data_a, data_b;
    logic          out_valid, out_ready;
    logic [PW-1:0] product;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [TW-1:0] tag;
        logic [PW-1:0] p;
    } exp_t;
    exp_t sb[$];

    logic          o_in_ready, o_out_valid;
    logic [TW-1:0] o_tag;
    logic [PW-1:0] o_prod;
    logic          e_ok;
    logic [TW-1:0] e_tag;
    logic [PW-1:0] e_prod;

    int_mult_pipe #(.DATA_WIDTH(W), .STAGES(S), .TAG_WIDTH(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_signed (in_signed),
        .in_tag    (in_tag),
        .data_a    (data_a),
        .data_b    (data_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_tag   (out_tag),
        .product   (product)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic sg);
        logic signed [PW-1:0] sa;
        logic signed [PW-1:0] sbv;
        if (sg) begin
            sa  = $signed({{W{a[W-1]}}, a});
            sbv = $signed({{W{b[W-1]}}, b});
            return PW'(sa * sbv);
        end
        return PW'(a) * PW'(b);
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 4))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h0;
            default: return $urandom;
        endcase
    endfunction

    // One clock: drive, sample mid-cycle, record transfers, advance past the edge.
    task automatic step(input logic v, input logic sg, input logic [TW-1:0] t,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic rdy);
        exp_t e;
        in_valid  = v;
        in_signed = sg;
        in_tag    = t;
        data_a    = a;
        data_b    = b;
        out_ready = rdy;
        @(negedge clk);
        o_in_ready  = in_ready;
        o_out_valid = out_valid;
        o_tag       = out_tag;
        o_prod      = product;
        e_ok        = 1'b0;
        e_tag       = '0;
        e_prod      = '0;
        if (out_valid && rdy && sb.size() > 0) begin
            e     = sb.pop_front();
            e_ok  = 1'b1;
            e_tag = e.tag;
            e_prod = e.p;
        end
        if (v && in_ready) begin
            e.tag = t;
            e.p   = ref_mul(a, b, sg);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 1'b0, '0, '0, '0, rdy);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(1'b0);
        idle(1'b0);
        rst = 1'b0;
        sb.delete();
        idle(1'b0);
        checks++; if (o_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", o_out_valid); end
        checks++; if (o_prod !== '0) begin failures++; $display("FAIL reset_product got=%h exp=0", o_prod); end
        checks++; if (o_tag !== '0) begin failures++; $display("FAIL reset_out_tag got=%h exp=0", o_tag); end
        checks++; if (o_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", o_in_ready); end
    endtask

    task automatic test_unsigned_basic();
        step(1'b1, 1'b0, 4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        checks++; if (o_in_ready !== 1'b1) begin failures++; $display("FAIL ubasic_in_ready got=%b exp=1", o_in_ready); end
        for (int k = 1; k <= 4; k++) begin
            idle(1'b1);
            if (k < 4) begin
                checks++; if (o_out_valid !== 1'b0) begin failures++; $display("FAIL ubasic_early_valid k=%0d got=%b exp=0", k, o_out_valid); end
            end else begin
                checks++; if (o_out_valid !== 1'b1) begin failures++; $display("FAIL ubasic_latency got=%b exp=1", o_out_valid); end
                checks++; if (o_prod !== 64'hFFFF_FFFE_0000_0001) begin failures++; $display("FAIL ubasic_product got=%h exp=fffffffe00000001", o_prod); end
                checks++; if (o_tag !== 4'd3) begin failures++; $display("FAIL ubasic_tag got=%h exp=3", o_tag); end
            end
        end
    endtask

    task automatic test_signed_corners();
        logic [W-1:0]  ca [3];
        logic [W-1:0]  cb [3];
        logic [PW-1:0] cp [3];
        int n = 0;
        ca[0] = 32'h8000_0000; cb[0] = 32'h8000_0000; cp[0] = 64'h4000_0000_0000_0000;
        ca[1] = 32'hFFFF_FFFF; cb[1] = 32'h0000_0007; cp[1] = 64'hFFFF_FFFF_FFFF_FFF9;
        ca[2] = 32'h0;         cb[2] = 32'h8000_0000; cp[2] = 64'h0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, TW'(i), ca[i], cb[i], 1'b1);
        for (int c = 0; c < 8; c++) begin
            idle(1'b1);
            if (o_out_valid && n < 3) begin
                checks++; if (o_prod !== cp[n]) begin failures++; $display("FAIL signed_corner_%0d got=%h exp=%h", n, o_prod, cp[n]); end
                checks++; if (o_tag !== TW'(n)) begin failures++; $display("FAIL signed_corner_tag got=%h exp=%h", o_tag, TW'(n)); end
                n++;
            end
        end
        checks++; if (n != 3) begin failures++; $display("FAIL signed_corner_count got=%0d exp=3", n); end
    endtask

    task automatic test_streaming();
        int nout = 0;
        int last = -1;
        for (int c = 0; c < 16; c++) begin
            if (c < 8) step(1'b1, 1'($urandom), TW'(c), pick_operand(), pick_operand(), 1'b1);
            else idle(1'b1);
            if (c < 8) begin
                checks++; if (o_in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready c=%0d got=%b exp=1", c, o_in_ready); end
            end
            if (o_out_valid) begin
                checks++; if (!e_ok || o_tag !== TW'(nout) || o_prod !== e_prod) begin
                    failures++; $display("FAIL stream_result n=%0d tag=%h exp_tag=%h got=%h exp=%h", nout, o_tag, TW'(nout), o_prod, e_prod);
                end
                if (nout == 0) begin
                    checks++; if (c != 4) begin failures++; $display("FAIL stream_first_cycle got=%0d exp=4", c); end
                end else begin
                    checks++; if (c != last + 1) begin failures++; $display("FAIL stream_gap got=%0d exp=%0d", c, last + 1); end
                end
                last = c;
                nout++;
            end
        end
        checks++; if (nout != 8) begin failures++; $display("FAIL stream_count got=%0d exp=8", nout); end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        logic [PW-1:0] held = '0;
        for (int c = 0; c < 6; c++) begin
            step(1'b1, 1'($urandom), TW'(acc), pick_operand(), pick_operand(), 1'b0);
            checks++; if (o_in_ready !== (c < 4)) begin failures++; $display("FAIL bp_in_ready c=%0d got=%b exp=%b", c, o_in_ready, (c < 4)); end
            if (o_in_ready) acc++;
            if (c == 4) begin
                held = o_prod;
                checks++; if (o_out_valid !== 1'b1 || o_prod !== sb[0].p) begin
                    failures++; $display("FAIL bp_head valid=%b got=%h exp=%h", o_out_valid, o_prod, sb[0].p);
                end
            end
            if (c == 5) begin
                checks++; if (o_prod !== held) begin failures++; $display("FAIL bp_hold got=%h exp=%h", o_prod, held); end
            end
        end
        checks++; if (acc != 4) begin failures++; $display("FAIL bp_accepted got=%0d exp=4", acc); end
        for (int r = 0; r < 6; r++) begin
            idle(1'b1);
            if (r < 4) begin
                checks++; if (o_out_valid !== 1'b1 || !e_ok || o_prod !== e_prod || o_tag !== TW'(r)) begin
                    failures++; $display("FAIL bp_drain r=%0d valid=%b got=%h exp=%h tag=%h", r, o_out_valid, o_prod, e_prod, o_tag);
                end
            end else begin
                checks++; if (o_out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain_end r=%0d got=%b exp=0", r, o_out_valid); end
            end
            if (r == 1) begin
                checks++; if (o_in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_after_drain got=%b exp=1", o_in_ready); end
            end
        end
    endtask

    task automatic test_bubble();
        int n = 0;
        step(1'b1, 1'b0, 4'hA, pick_operand(), pick_operand(), 1'b0);
        checks++; if (o_in_ready !== 1'b1) begin failures++; $display("FAIL bubble_ready_a got=%b exp=1", o_in_ready); end
        idle(1'b0);
        idle(1'b0);
        step(1'b1, 1'b1, 4'hB, pick_operand(), pick_operand(), 1'b0);
        checks++; if (o_in_ready !== 1'b1) begin failures++; $display("FAIL bubble_ready_b got=%b exp=1", o_in_ready); end
        idle(1'b0);
        idle(1'b0);
        checks++; if (o_out_valid !== 1'b1 || o_tag !== 4'hA || o_prod !== sb[0].p) begin
            failures++; $display("FAIL bubble_head valid=%b tag=%h got=%h exp=%h", o_out_valid, o_tag, o_prod, sb[0].p);
        end
        checks++; if (o_in_ready !== 1'b1) begin failures++; $display("FAIL bubble_ready_half got=%b exp=1", o_in_ready); end
        for (int c = 0; c < 8; c++) begin
            idle(1'b1);
            if (o_out_valid) begin
                checks++; if (!e_ok || o_prod !== e_prod || o_tag !== (n == 0 ? 4'hA : 4'hB)) begin
                    failures++; $display("FAIL bubble_result n=%0d tag=%h got=%h exp=%h", n, o_tag, o_prod, e_prod);
                end
                n++;
            end
        end
        checks++; if (n != 2) begin failures++; $display("FAIL bubble_count got=%0d exp=2", n); end
    endtask

    task automatic test_reset_midflight();
        logic [W-1:0] a, b;
        for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom), TW'(i + 5), pick_operand(), pick_operand(), 1'b1);
        rst = 1'b1;
        idle(1'b1);
        rst = 1'b0;
        sb.delete();
        idle(1'b1);
        checks++; if (o_out_valid !== 1'b0 || o_prod !== '0) begin
            failures++; $display("FAIL midrst_clear valid=%b got=%h exp=0", o_out_valid, o_prod);
        end
        for (int c = 0; c < 5; c++) begin
            idle(1'b1);
            checks++; if (o_out_valid !== 1'b0) begin failures++; $display("FAIL midrst_stale c=%0d got=%b exp=0", c, o_out_valid); end
        end
        a = pick_operand();
        b = pick_operand();
        step(1'b1, 1'b1, 4'hC, a, b, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            idle(1'b1);
            if (k < 4) begin
                checks++; if (o_out_valid !== 1'b0) begin failures++; $display("FAIL midrst_early k=%0d got=%b exp=0", k, o_out_valid); end
            end else begin
                checks++; if (o_out_valid !== 1'b1 || o_tag !== 4'hC || o_prod !== ref_mul(a, b, 1'b1)) begin
                    failures++; $display("FAIL midrst_new valid=%b tag=%h got=%h exp=%h", o_out_valid, o_tag, o_prod, ref_mul(a, b, 1'b1));
                end
            end
        end
    endtask

    task automatic test_random();
        int occ;
        logic rdy;
        for (int c = 0; c < 400; c++) begin
            occ = sb.size();
            rdy = c < 360 ? 1'($urandom_range(0, 3) != 0) : 1'b1;
            if (c < 360) step(1'($urandom), 1'($urandom), TW'($urandom), pick_operand(), pick_operand(), rdy);
            else idle(rdy);
            checks++; if (o_in_ready !== ((occ < S) || rdy)) begin
                failures++; $display("FAIL rand_in_ready c=%0d got=%b exp=%b occ=%0d", c, o_in_ready, ((occ < S) || rdy), occ);
            end
            if (o_out_valid && rdy) begin
                checks++; if (!e_ok || o_prod !== e_prod || o_tag !== e_tag) begin
                    failures++; $display("FAIL rand_result c=%0d tag=%h exp_tag=%h got=%h exp=%h", c, o_tag, e_tag, o_prod, e_prod);
                end
            end
        end
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL rand_lost got=%0d exp=0", sb.size()); end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_signed = 1'b0;
        in_tag    = '0;
        data_a    = '0;
        data_b    = '0;
        out_ready = 1'b0;
        test_reset();
        test_unsigned_basic();
        test_signed_corners();
        test_streaming();
        test_backpressure();
        test_bubble();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/int_mult_pipe.md
Name: int_mult_pipe

Overview:
- Parametrised, fully pipelined integer multiplier for the int_alu datapath.
- Generalises the single multiplier stage adder into a configurable-depth pipeline: DATA_WIDTH x DATA_WIDTH -> 2*DATA_WIDTH product.
- Adds per-operation signed/unsigned mode, a sideband tag, and valid/ready handshakes with per-stage backpressure and bubble collapsing.
- Sits between the ALU issue logic and the result writeback arbiter.

Parameters:
- DATA_WIDTH, 32, operand width; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages; each stage adds DATA_WIDTH/STAGES partial products. Legal range 1..DATA_WIDTH.
- TAG_WIDTH, 4, width of the opaque tag carried alongside each operation.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operation offered.
- in_ready  output  1  pipeline can accept this cycle.
- in_signed  input  1  1 = treat operands as two's complement; 0 = unsigned.
- in_tag  input  TAG_WIDTH  sideband returned with the result.
- data_a  input  DATA_WIDTH  multiplicand.
- data_b  input  DATA_WIDTH  multiplier.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_tag  output  TAG_WIDTH  tag of the presented result.
- product  output  2*DATA_WIDTH  full-width product.

Behaviour:
- Reset: one clock and one reset. Reset is synchronous and active-high; all stage valid bits clear on the clk edge with rst=1. out_valid=0, product=0 and out_tag=0 after reset. in_ready=1 in the first cycle after reset deasserts. Reset mid-operation discards all in-flight operations; no partial result is ever presented.
- Transfers: an input transfer occurs when in_valid&in_ready at a rising edge. An output transfer occurs when out_valid&out_ready.
- Operand conditioning at stage 0 entry:
  - Signed mode: take magnitudes |a| and |b| as DATA_WIDTH-bit unsigned. The magnitude of -2^(W-1) is 2^(W-1), which fits. Record neg = a_sign XOR b_sign.
  - Unsigned mode: neg=0.
- Stage s (0..STAGES-1) register holds {valid, tag, neg, |a|, |b|, acc}.
  - acc is 2*DATA_WIDTH bits.
  - acc_s = acc_(s-1) + sum over bits j in chunk s of (|b|[j] ? |a|<<j : 0).
  - Chunk s covers multiplier bits [s*K .. s*K+K-1], where K=DATA_WIDTH/STAGES.
  - acc_(-1)=0.
- Final stage: when loading stage STAGES-1, acc is negated (two's complement, 2*DATA_WIDTH bits) if neg=1. product and out_tag are driven directly from the stage STAGES-1 register; out_valid = its valid bit.
- Advance rule, from the last stage back:
  - adv[S-1] = ~v[S-1] | out_ready.
  - adv[s] = ~v[s] | adv[s+1].
  - in_ready = adv[0].
- Stage s loads from stage s-1 (or the input for s=0) when adv[s]. Its valid bit becomes v[s-1] (or in_valid&in_ready). Bubbles collapse: an empty stage always accepts.
- Holding: when out_valid=1 and out_ready=0, product/out_tag are held stable and upstream stages fill until full. in_ready falls only when all STAGES stages are valid.
- Latency: STAGES cycles from the input-transfer cycle to the out_valid cycle when unstalled. Throughput is 1 per cycle with out_ready=1. Simultaneous input and output transfers in the same cycle are legal at full occupancy.
- Arithmetic: the product is exact; no overflow is possible in 2*DATA_WIDTH bits for either mode. Results emerge in input order.
- Ordering with valid=0: data on in_* while in_valid=0 is ignored and does not alter state beyond don't-care payload. Payload registers of invalid stages may be left unchanged.

Decomposition:
- Shared package int_alu_pkg holds:
  - the mode encoding constants (MODE_UNSIGNED=1'b0, MODE_SIGNED=1'b1);
  - a function for the partial-product chunk width K;
  - the default DATA_WIDTH constant.
- One sub-module, int_mult_pipe_stage: a parameterised by STAGE_IDX register slice with chunk adder, optional final negate (enabled when STAGE_IDX==STAGES-1), and local advance logic. The top is a generate loop plus the operand-conditioning logic.

Test Plan:
- Unsigned basic, W=32, S=4: a=0xFFFFFFFF, b=0xFFFFFFFF, signed=0, tag=3 -> exactly 4 cycles later out_valid=1, product=0xFFFFFFFE00000001, out_tag=3.
- Signed corners: a=0x80000000, b=0x80000000 -> 0x4000000000000000; a=0xFFFFFFFF (-1), b=7 -> 0xFFFFFFFFFFFFFFF9; a=0, b=0x80000000 -> 0.
- Streaming: 8 back-to-back transfers with out_ready=1 and tags 0..7 -> 8 consecutive out_valid cycles, tags 0..7 in order, in_ready never low.
- Backpressure: hold out_ready=0 while issuing -> in_ready falls after exactly 4 accepted ops, product stable. Release out_ready -> one result per cycle, in_ready=1 the cycle after first drain.
- Bubble collapse: issue op, idle 2 cycles, issue op, with out_ready=0 -> both ops occupy stages 3 and 2 and none are lost; results arrive in order after release.
- Reset mid-flight: 3 ops in flight, assert rst one cycle -> out_valid=0 and product=0 next cycle, no stale result ever appears, new op completes normally with 4-cycle latency.
